// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared types and helpers for the LC-3 memory access unit.
//   state_e  : access FSM states (IDLE / ACCESS / DONE)
//   io_addr(): all-ones I/O address for a given address width
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // All-ones address of width w (1..64); the caller casts to its own width.
  function automatic logic [63:0] io_addr(input int unsigned w);
    return {64{1'b1}} >> (64 - w);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Request/response handshake between the control FSM and the memory access
// unit, plus the asynchronous SRAM-style port driven by the unit.
//   req_valid/req_write/req_addr/req_wdata : request from control FSM
//   req_ready                              : unit can accept a request
//   resp_valid/resp_rdata                  : one-cycle completion pulse + MDR
//   mem_addr/mem_wdata/mem_rdata           : SRAM address / write / read data
//   mem_ce_n/mem_oe_n/mem_we_n             : SRAM strobes, active-low
// Modports: slave = the access unit, master = control FSM + SRAM side.
interface mem_access_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ce_n;
  logic              mem_oe_n;
  logic              mem_we_n;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/mem_ld_reg.sv
// mem_ld_reg
// Parametrised load-enable register with synchronous active-low clear.
//   clk   : clock
//   rst_n : synchronous clear to zero, active-low
//   en    : load d on the rising edge
//   d / q : data in / registered data out
module mem_ld_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_wait_counter.sv
// mem_wait_counter
// Loadable down-counter timing how long a memory strobe is held.
//   clk   : clock
//   rst_n : synchronous clear, active-low
//   load  : load WAIT_CYCLES-1
//   dec   : decrement (saturates at zero)
//   zero  : counter currently equals zero
module mem_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (load)                  cnt_q <= LOAD_VAL;
    else if (dec && (cnt_q != '0))  cnt_q <= cnt_q - CNT_W'(1);
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// LC-3 memory access unit: owns MAR/MDR, serialises control-FSM requests
// onto an asynchronous SRAM port with WAIT_CYCLES of strobe hold time and
// returns a one-cycle response pulse. Also provides the pause display mux.
// Ports:
//   Clk, Reset  : clock, synchronous active-low reset
//   bus         : mem_access_unit_if.slave (request/response + SRAM port)
//   pause/ir_in : pause display mode, IR value shown while paused
//   disp_addr   : pause ? all-ones : MAR
//   disp_data   : pause ? ir_in : MDR
//   sw_in       : switch inputs (I/O map read)
//   hex_out     : hex-display register (I/O map write)
// Optional feature macro: MEM_ACCESS_IOMAP_EN -- when defined, the all-ones
// address is serviced locally (sw_in / hex_out) without SRAM strobes; when
// undefined every address goes to SRAM and hex_out is tied to zero.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_access_unit_if.slave  bus,
  input  logic              pause,
  input  logic [DATA_W-1:0] ir_in,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] hex_out
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              mar_en, mdr_en, hex_en;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              write_q, write_nxt;
  logic              io_hit;
  logic              ce_n_q, oe_n_q, we_n_q;

  // Address decode for the local I/O location
`ifdef MEM_ACCESS_IOMAP_EN
  localparam logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(io_addr(ADDR_W));
  assign io_hit = (bus.req_addr == IO_ADDR);

  mem_ld_reg #(.W(DATA_W)) u_hex (
    .clk   (Clk),
    .rst_n (Reset),
    .en    (hex_en),
    .d     (bus.req_wdata),
    .q     (hex_out)
  );
`else
  logic unused_io;
  assign io_hit    = 1'b0;
  assign hex_out   = '0;
  assign unused_io = hex_en;
`endif

  // MAR / MDR
  mem_ld_reg #(.W(ADDR_W)) u_mar (
    .clk   (Clk),
    .rst_n (Reset),
    .en    (mar_en),
    .d     (bus.req_addr),
    .q     (mar_q)
  );

  mem_ld_reg #(.W(DATA_W)) u_mdr (
    .clk   (Clk),
    .rst_n (Reset),
    .en    (mdr_en),
    .d     (mdr_d),
    .q     (mdr_q)
  );

  mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  // FSM state register and latched access direction
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mar_en) write_q <= bus.req_write;
    end
  end

  // Next state and datapath enables
  always_comb begin
    state_d  = state_q;
    mar_en   = 1'b0;
    mdr_en   = 1'b0;
    mdr_d    = bus.req_wdata;
    hex_en   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mar_en = 1'b1;
          if (io_hit) begin
            // I/O location completes immediately without touching SRAM
            mdr_en  = 1'b1;
            mdr_d   = bus.req_write ? bus.req_wdata : sw_in;
            hex_en  = bus.req_write;
            state_d = DONE;
          end else begin
            mdr_en   = bus.req_write;
            cnt_load = 1'b1;
            state_d  = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          mdr_en  = ~write_q;
          mdr_d   = bus.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are flops fed from the next state, so the SRAM pins never see a
  // combinational path from the request inputs. In IDLE the direction comes
  // straight from the request being accepted.
  assign write_nxt = (state_q == IDLE) ? bus.req_write : write_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ce_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      we_n_q <= 1'b1;
    end else begin
      ce_n_q <= (state_d != ACCESS);
      oe_n_q <= !((state_d == ACCESS) && !write_nxt);
      we_n_q <= !((state_d == ACCESS) &&  write_nxt);
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_rdata = mdr_q;
  assign bus.mem_addr   = mar_q;
  assign bus.mem_wdata  = mdr_q;
  assign bus.mem_ce_n   = ce_n_q;
  assign bus.mem_oe_n   = oe_n_q;
  assign bus.mem_we_n   = we_n_q;

  assign disp_addr = pause ? '1 : mar_q;
  assign disp_data = pause ? ir_in : mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        Clk;
  logic        Reset;
  logic        pause;
  logic [15:0] ir_in, sw_in;
  logic [15:0] disp_addr, disp_data, hex_out;
  logic [15:0] disp_addr1, disp_data1, hex_out1;

  mem_access_unit_if #(.DATA_W(16), .ADDR_W(16)) bus  ();
  mem_access_unit_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .pause(pause), .ir_in(ir_in),
    .disp_addr(disp_addr), .disp_data(disp_data), .sw_in(sw_in), .hex_out(hex_out)
  );

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(bus1), .pause(pause), .ir_in(ir_in),
    .disp_addr(disp_addr1), .disp_data(disp_data1), .sw_in(sw_in), .hex_out(hex_out1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;   // value the SRAM returns during the access
    logic [15:0] exp;     // expected resp_rdata
  } vec_t;

  vec_t vecs[5];

  // Drives one request from the start of an idle cycle (cycle 0) and checks
  // cycles 0..3; returns #1 into cycle 4, where the unit is idle again.
  task automatic run_vec(input vec_t v);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.mem_rdata = v.rdata;
    @(negedge Clk);
    chk("c0_ready", bus.req_ready, 1);
    chk("c0_ce_n", bus.mem_ce_n, 1);
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = ~v.addr;
    bus.req_wdata = ~v.wdata;
    for (int c = 1; c <= 2; c++) begin
      @(negedge Clk);
      chk($sformatf("c%0d_ce_n", c), bus.mem_ce_n, 0);
      chk($sformatf("c%0d_oe_n", c), bus.mem_oe_n, v.wr);
      chk($sformatf("c%0d_we_n", c), bus.mem_we_n, !v.wr);
      chk($sformatf("c%0d_addr", c), bus.mem_addr, v.addr);
      if (v.wr) chk($sformatf("c%0d_wdata", c), bus.mem_wdata, v.wdata);
      chk($sformatf("c%0d_ready", c), bus.req_ready, 0);
      chk($sformatf("c%0d_resp", c), bus.resp_valid, 0);
      @(posedge Clk); #1;
    end
    @(negedge Clk);
    chk("c3_resp", bus.resp_valid, 1);
    chk("c3_rdata", bus.resp_rdata, v.exp);
    chk("c3_strobes", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 3'b111);
    chk("c3_ready", bus.req_ready, 0);
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{wr:1'b0, addr:16'h3000, wdata:16'h0000, rdata:16'h1234, exp:16'h1234};
    vecs[1] = '{wr:1'b1, addr:16'h4000, wdata:16'hBEEF, rdata:16'h9999, exp:16'hBEEF};
    vecs[2] = '{wr:1'b0, addr:16'h0000, wdata:16'h1111, rdata:16'hFFFF, exp:16'hFFFF};
    vecs[3] = '{wr:1'b0, addr:16'h8001, wdata:16'h2222, rdata:16'h0001, exp:16'h0001};
    vecs[4] = '{wr:1'b1, addr:16'h3001, wdata:16'hA5A5, rdata:16'h0000, exp:16'hA5A5};

    Reset = 1'b0; pause = 1'b0; ir_in = 16'h0; sw_in = 16'h00A5;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.mem_rdata = 0;
    bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = 0; bus1.req_wdata = 0; bus1.mem_rdata = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_resp", bus.resp_valid, 0);
    chk("rst_strobes", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 3'b111);
    chk("rst_mar", bus.mem_addr, 0);
    chk("rst_mdr", bus.mem_wdata, 0);
    chk("rst_hex", hex_out, 0);
    Reset = 1'b1;
    @(posedge Clk); #1;

    // Table of back-to-back accesses
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Pause display mux (MAR=0x3001, MDR=0xA5A5 from the last vector)
    pause = 1'b1; ir_in = 16'h5020;
    @(negedge Clk);
    chk("pause_addr", disp_addr, 16'hFFFF);
    chk("pause_data", disp_data, 16'h5020);
    pause = 1'b0;
    @(negedge Clk);
    chk("nopause_addr", disp_addr, 16'h3001);
    chk("nopause_data", disp_data, 16'hA5A5);
    @(posedge Clk); #1;

    // Reset during cycle 1 of a read
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 16'h5555; bus.mem_rdata = 16'h7777;
    @(posedge Clk); #1;
    bus.req_valid = 0;
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_c1_ce_n", bus.mem_ce_n, 0);
    chk("abort_c1_mar", bus.mem_addr, 16'h5555);
    @(negedge Clk);
    chk("abort_strobes", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 3'b111);
    chk("abort_mar", bus.mem_addr, 0);
    chk("abort_mdr", bus.mem_wdata, 0);
    chk("abort_idle", bus.req_ready, 1);
    chk("abort_resp", bus.resp_valid, 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    run_vec('{wr:1'b0, addr:16'h6000, wdata:16'h0, rdata:16'h0BAD, exp:16'h0BAD});

`ifdef MEM_ACCESS_IOMAP_EN
    // Local I/O read: response in cycle 1, no strobes
    sw_in = 16'h00A5;
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 16'hFFFF; bus.mem_rdata = 16'h1111;
    @(posedge Clk); #1;
    bus.req_valid = 0;
    @(negedge Clk);
    chk("io_rd_resp", bus.resp_valid, 1);
    chk("io_rd_data", bus.resp_rdata, 16'h00A5);
    chk("io_rd_ce_n", bus.mem_ce_n, 1);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("io_rd_ready", bus.req_ready, 1);
    // Local I/O write
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 16'hFFFF; bus.req_wdata = 16'h0042;
    @(posedge Clk); #1;
    bus.req_valid = 0;
    @(negedge Clk);
    chk("io_wr_resp", bus.resp_valid, 1);
    chk("io_wr_hex", hex_out, 16'h0042);
    chk("io_wr_we_n", bus.mem_we_n, 1);
    @(posedge Clk); #1;
`else
    // Without the I/O map, 0xFFFF is an ordinary SRAM location
    run_vec('{wr:1'b1, addr:16'hFFFF, wdata:16'h0042, rdata:16'h0, exp:16'h0042});
    chk("noio_hex", hex_out, 0);
`endif

    // WAIT_CYCLES=1 unit with req_valid held high throughout
    begin
      logic [6:0] exp_ready, exp_ce_n, exp_resp;
      int accepts;
      exp_ready = 7'b1001001;   // bit i = cycle i
      exp_ce_n  = 7'b1101101;
      exp_resp  = 7'b0100100;
      accepts   = 0;
      bus1.req_valid = 1; bus1.req_write = 0; bus1.req_addr = 16'h1000; bus1.mem_rdata = 16'h0011;
      for (int i = 0; i < 7; i++) begin
        @(negedge Clk);
        if (bus1.req_ready) accepts++;
        chk($sformatf("w1_c%0d_ready", i), bus1.req_ready, exp_ready[i]);
        chk($sformatf("w1_c%0d_ce_n", i), bus1.mem_ce_n, exp_ce_n[i]);
        chk($sformatf("w1_c%0d_resp", i), bus1.resp_valid, exp_resp[i]);
        if (exp_resp[i]) chk($sformatf("w1_c%0d_rdata", i), bus1.resp_rdata, 16'h0011);
        @(posedge Clk); #1;
      end
      bus1.req_valid = 0;
      chk("w1_accepts", accepts, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory access unit for the LC-3 datapath: owns MAR and MDR, serialises read/write requests from the control FSM onto an asynchronous SRAM-style port with a configurable number of wait cycles, and returns read data with a one-cycle response pulse. It replaces the fixed-timing Mem_OE/Mem_WE/MIO_EN path. It also provides the pause-mode display mux, which shows IR on the LEDs/hex in place of MAR/MDR.

## Interface
- DATA_W, 16, data/MDR width
- ADDR_W, 16, address/MAR width
- WAIT_CYCLES, 2, cycles a memory strobe is held (≥1)

- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- req_valid  in  1  control FSM requests an access
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  access address, captured into MAR
- req_wdata  in  DATA_W  write data, captured into MDR
- req_ready  out  1  unit can accept a request
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  DATA_W  MDR contents, valid with resp_valid
- mem_addr  out  ADDR_W  SRAM address (= MAR)
- mem_wdata  out  DATA_W  SRAM write data (= MDR)
- mem_rdata  in  DATA_W  SRAM read data
- mem_ce_n, mem_oe_n, mem_we_n  out  1 each  SRAM strobes, active-low
- pause  in  1  display-pause mode
- ir_in  in  DATA_W  current IR for pause display
- disp_addr  out  ADDR_W  pause ? all-ones : MAR
- disp_data  out  DATA_W  pause ? ir_in : MDR
- sw_in  in  DATA_W  switch inputs (I/O map)
- hex_out  out  DATA_W  hex-display register (I/O map)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: req_ready=1. If req_valid is high, the request is accepted: MAR←req_addr, and MDR←req_wdata on a write. The cycle counter is loaded with WAIT_CYCLES−1. Next state is ACCESS.
- ACCESS: mem_ce_n=0, plus mem_oe_n=0 (read) or mem_we_n=0 (write). The counter decrements each cycle. When the counter = 0, a read captures MDR←mem_rdata, and the next state is DONE.
- DONE: all strobes high; resp_valid=1; resp_rdata=MDR. Next state is IDLE.
- req_ready is 0 in ACCESS and DONE. req_valid is ignored there, with no queueing.
- mem_addr/mem_wdata track MAR/MDR in every state.
- disp_addr/disp_data are combinational from pause and are independent of FSM state.
- Widths are independent: no truncation between ADDR_W and DATA_W paths.

## Timing
- Reset (Reset=0 at an edge), including mid-access:
  - State returns to IDLE.
  - MAR, MDR, hex_out are cleared to 0.
  - resp_valid=0.
  - All strobes go high on that same edge.
  - The aborted access produces no response.
- Memory access latency: accept at cycle 0; strobes low in cycles 1..WAIT_CYCLES; resp_valid in cycle WAIT_CYCLES+1; req_ready high again in cycle WAIT_CYCLES+2.
- Back-to-back accesses: throughput is one access per WAIT_CYCLES+2 cycles.
- Strobes never glitch: they are registered from state, with no combinational path from req_* inputs.
- WAIT_CYCLES=1: ACCESS lasts exactly one cycle.

## Configuration
- MEM_ACCESS_IOMAP_EN defined:
  - Address all-ones (I/O address) is serviced locally, with no strobes.
  - Read: MDR←sw_in at accept; next state is DONE, so resp_valid is in cycle 1.
  - Write: hex_out←req_wdata at accept; resp_valid in cycle 1.
  - All other addresses go to SRAM as normal.
- MEM_ACCESS_IOMAP_EN undefined: every address goes to SRAM; sw_in is ignored; hex_out is tied to 0.

## Structure
- Shared package mem_access_pkg holds:
  - the state enum typedef (IDLE/ACCESS/DONE)
  - a localparam function returning the all-ones I/O address for a given ADDR_W
- One sub-module, mem_wait_counter: loadable down-counter, width $clog2(WAIT_CYCLES+1), with load, decrement and zero flag.
- MAR/MDR/hex_out use the codebase's existing parametrised load-enable register.

## Test plan
All scenarios use defaults (16/16, WAIT_CYCLES=2) unless stated.
- Read 0x3000, SRAM returns 0x1234 → strobes mem_ce_n/mem_oe_n low in cycles 1–2; resp_valid=1 with resp_rdata=0x1234 in cycle 3; req_ready=1 in cycle 4.
- Write 0xBEEF to 0x4000 → mem_we_n low in cycles 1–2, mem_addr=0x4000, mem_wdata=0xBEEF; resp_valid in cycle 3; mem_oe_n stays high throughout.
- Reset driven low in cycle 1 of a read → next edge: strobes high, MAR=MDR=0, FSM in IDLE, no resp_valid ever; a new request is accepted the cycle Reset returns high.
- With MEM_ACCESS_IOMAP_EN, read 0xFFFF with sw_in=0x00A5 → no strobes; resp_valid in cycle 1 with resp_rdata=0x00A5. Write 0x0042 to 0xFFFF → hex_out=0x0042 from cycle 1.
- pause=1, ir_in=0x5020, MAR=0x3001 → disp_addr=0xFFFF, disp_data=0x5020. pause=0 → disp_addr=0x3001, disp_data=MDR.
- WAIT_CYCLES=1 with req_valid held high → the 2nd request is accepted in cycle 3 (one ACCESS cycle); req_valid held during busy cycles causes no extra accepts.
